// File: rtl/md_unit_pkg.sv
// Shared MIPS definitions: md-class op codes and
// multiply/divide latency defaults.
package mips_defs;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;
  localparam int CNT_W       = 8;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } md_state_t;

endpackage

// File: rtl/md_unit_if.sv
// E-stage to md_unit request/response bundle.
// master drives the request, slave is the unit.
interface md_unit_if;
  logic        in_start;
  logic [3:0]  in_md_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] out_md_out;
  logic        out_busy;
  logic [31:0] out_hi;
  logic [31:0] out_lo;

  modport master (
    output in_start, in_md_op, in_a, in_b,
    input  out_md_out, out_busy, out_hi, out_lo
  );

  modport slave (
    input  in_start, in_md_op, in_a, in_b,
    output out_md_out, out_busy, out_hi, out_lo
  );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle mult/div unit owning HI/LO.
// Result is computed from latched operands only.
module md_unit
  import mips_defs::*;
#(
  parameter int MULT_CYCLES = mips_defs::MULT_CYCLES,
  parameter int DIV_CYCLES  = mips_defs::DIV_CYCLES
) (
  input  logic     clk,
  input  logic     reset,
  md_unit_if.slave md
);

  md_state_t        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       op_q;
  logic [31:0]      a_q, b_q;
  logic [31:0]      hi, lo, hi_n, lo_n;
  logic             latch;

  logic        is_mul, is_div, sdiv;
  logic [63:0] prod;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag;
  logic [31:0] quo, rem;

  always_comb begin
    sdiv  = (op_q == MD_DIV);
    a_neg = sdiv & a_q[31];
    b_neg = sdiv & b_q[31];
    a_mag = a_neg ? -a_q : a_q;
    b_mag = b_neg ? -b_q : b_q;
    q_mag = a_mag / b_mag;
    r_mag = a_mag % b_mag;
    // Sign-magnitude keeps 0x80000000/-1 well defined
    quo   = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem   = a_neg ? -r_mag : r_mag;
    if (op_q == MD_MULT)
      prod = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    else
      prod = {32'b0, a_q} * {32'b0, b_q};
  end

  assign is_mul = (md.in_md_op == MD_MULT)
                | (md.in_md_op == MD_MULTU);
  assign is_div = (md.in_md_op == MD_DIV)
                | (md.in_md_op == MD_DIVU);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hi_n    = hi;
    lo_n    = lo;
    latch   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (md.in_start) begin
          unique case (1'b1)
            is_mul: begin
              latch   = 1'b1;
              cnt_n   = CNT_W'(MULT_CYCLES);
              state_n = S_RUN;
            end
            is_div: begin
              latch   = 1'b1;
              cnt_n   = CNT_W'(DIV_CYCLES);
              state_n = S_RUN;
            end
            (md.in_md_op == MD_MTHI): hi_n = md.in_a;
            (md.in_md_op == MD_MTLO): lo_n = md.in_a;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        cnt_n = cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          state_n = S_IDLE;
          if (op_q == MD_MULT || op_q == MD_MULTU) begin
            hi_n = prod[63:32];
            lo_n = prod[31:0];
          end else if (b_q != 32'b0) begin
            hi_n = rem;
            lo_n = quo;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      op_q  <= MD_NONE;
      a_q   <= '0;
      b_q   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      hi    <= hi_n;
      lo    <= lo_n;
      if (latch) begin
        op_q <= md.in_md_op;
        a_q  <= md.in_a;
        b_q  <= md.in_b;
      end
    end
  end

  always_comb begin
    md.out_md_out = 32'b0;
    if (md.in_md_op == MD_MFHI)
      md.out_md_out = hi;
    else if (md.in_md_op == MD_MFLO)
      md.out_md_out = lo;
  end

  assign md.out_busy = (state == S_RUN);
  assign md.out_hi   = hi;
  assign md.out_lo   = lo;

endmodule

// File: tb/tb_md_unit.sv
// Directed vector bench for md_unit.
// Vectors run back to back so HI/LO carry over.
module tb_md_unit;
  import mips_defs::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  md_unit_if bus ();

  md_unit dut (
    .clk   (clk),
    .reset (reset),
    .md    (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          cyc;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t v [11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] got,
                     logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic drive(logic s, logic [3:0] op,
                       logic [31:0] a, logic [31:0] b);
    bus.in_start = s;
    bus.in_md_op = op;
    bus.in_a     = a;
    bus.in_b     = b;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.out_busy === 1'b1 && n < 40) begin
      n++;
      step();
    end
  endtask

  task automatic read_hl(string nm, logic [31:0] h,
                         logic [31:0] l);
    chk({nm, ".hi"}, bus.out_hi, h);
    chk({nm, ".lo"}, bus.out_lo, l);
    bus.in_md_op = MD_MFHI;
    #1;
    chk({nm, ".mfhi"}, bus.out_md_out, h);
    bus.in_md_op = MD_MFLO;
    #1;
    chk({nm, ".mflo"}, bus.out_md_out, l);
    bus.in_md_op = MD_NONE;
    #1;
    chk({nm, ".none"}, bus.out_md_out, 32'h0);
  endtask

  initial begin
    int n;
    v[0]  = '{MD_MTHI,  32'h11, 32'h0, 0,
              32'h11, 32'h0};
    v[1]  = '{MD_MTLO,  32'h22, 32'h0, 0,
              32'h11, 32'h22};
    v[2]  = '{MD_DIV,   32'h5, 32'h0, 10,
              32'h11, 32'h22};
    v[3]  = '{MD_MULT,  32'hFFFFFFFE, 32'h3, 5,
              32'hFFFFFFFF, 32'hFFFFFFFA};
    v[4]  = '{MD_MULTU, 32'hFFFFFFFF, 32'h2, 5,
              32'h1, 32'hFFFFFFFE};
    v[5]  = '{MD_DIVU,  32'h7, 32'h2, 10,
              32'h1, 32'h3};
    v[6]  = '{MD_DIV,   32'hFFFFFFF9, 32'h2, 10,
              32'hFFFFFFFF, 32'hFFFFFFFD};
    v[7]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 10,
              32'h0, 32'h80000000};
    v[8]  = '{MD_MTHI,  32'hDEADBEEF, 32'h0, 0,
              32'hDEADBEEF, 32'h80000000};
    v[9]  = '{MD_DIV,   32'h7, 32'hFFFFFFFE, 10,
              32'h1, 32'hFFFFFFFD};
    v[10] = '{MD_MULT,  32'h80000000, 32'h80000000, 5,
              32'h40000000, 32'h0};

    reset = 1'b1;
    drive(1'b0, MD_NONE, 32'h0, 32'h0);
    step();
    step();
    reset = 1'b0;
    chk("rst.busy", {31'b0, bus.out_busy}, 32'h0);
    read_hl("rst", 32'h0, 32'h0);

    for (int i = 0; i < 11; i++) begin
      drive(1'b1, v[i].op, v[i].a, v[i].b);
      step();
      drive(1'b0, MD_NONE, 32'hA5A5A5A5, 32'h5A5A5A5A);
      wait_idle(n);
      chk($sformatf("v%0d.busy", i), n, v[i].cyc);
      read_hl($sformatf("v%0d", i), v[i].hi, v[i].lo);
    end

    // start during RUN is ignored; operands stay latched
    drive(1'b1, MD_MULT, 32'h3, 32'h4);
    step();
    drive(1'b1, MD_MTLO, 32'h55, 32'h9);
    chk("ign.busy1", {31'b0, bus.out_busy}, 32'h1);
    step();
    drive(1'b0, MD_NONE, 32'h77, 32'h66);
    chk("ign.lo_mid", bus.out_lo, 32'h0);
    wait_idle(n);
    chk("ign.busy_rest", n, 4);
    read_hl("ign", 32'h0, 32'hC);

    // reset in busy cycle 4 of a div aborts it
    drive(1'b1, MD_MTHI, 32'h1234, 32'h0);
    step();
    drive(1'b1, MD_DIV, 32'd100, 32'd7);
    step();
    drive(1'b0, MD_NONE, 32'h0, 32'h0);
    step();
    step();
    step();
    chk("rip.busy4", {31'b0, bus.out_busy}, 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rip.busy", {31'b0, bus.out_busy}, 32'h0);
    read_hl("rip", 32'h0, 32'h0);
    n = 0;
    for (int c = 0; c < 12; c++) begin
      if (bus.out_busy !== 1'b0) n++;
      step();
    end
    chk("rip.late_busy", n, 0);
    read_hl("rip_late", 32'h0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
